// File: rtl/dmem_seq_ctrl.sv
// dmem_seq_ctrl -- sequencer/scheduler for the shared 32-bit data memory.
//
// This block turns button-level store and fetch requests into single-cycle
// DMem write and read transactions. Stores get auto-incrementing addresses,
// and address 0 is never used. The latest address per operand slot (A/B) is
// remembered. A fetch reads A and then B, honouring the DMem read latency,
// and presents both operands with a one-cycle done strobe.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   i_store_req           level request, rising edge = one store
//   i_store_slot          0 = operand A, 1 = operand B
//   i_store_data          store word, sampled on the store_req rising edge
//   i_fetch_req           level request, rising edge = fetch A then B
//   o_mem_read/o_mem_write/o_mem_addr/o_mem_din  registered DMem controls
//   i_mem_dout            DMem read data (valid RD_LAT cycles after read)
//   o_op_a/o_op_b         last fetched operands
//   o_addr_a/o_addr_b     address of latest A/B store
//   o_busy                high whenever the sequencer is not idle
//   o_done                one-cycle pulse when op_a/op_b are updated
//   o_err                 one-cycle pulse on a rejected request
module dmem_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_store_req,
  input  logic              i_store_slot,
  input  logic [31:0]       i_store_data,
  input  logic              i_fetch_req,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_din,
  input  logic [31:0]       i_mem_dout,
  output logic [31:0]       o_op_a,
  output logic [31:0]       o_op_b,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B, S_DONE
  } state_t;

  state_t              r_state;
  logic                r_store_prev, r_fetch_prev;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_valid_a, r_valid_b, r_fetch_pend;
  logic [1:0]          r_wcnt;
  logic                r_mem_read, r_mem_write, r_done, r_err;
  logic [ADDR_W-1:0]   r_mem_addr, r_addr_a, r_addr_b;
  logic [31:0]         r_mem_din, r_op_a, r_op_b;

  logic                w_store_pulse, w_fetch_pulse;
  logic [ADDR_W-1:0]   w_ptr_next;

  assign w_store_pulse = i_store_req & ~r_store_prev;
  assign w_fetch_pulse = i_fetch_req & ~r_fetch_prev;
  // Address 0 is reserved, so the pointer wraps from all-ones back to 1.
  assign w_ptr_next = (r_ptr == '1) ? ADDR_W'(1) : r_ptr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_store_prev <= 1'b0;
      r_fetch_prev <= 1'b0;
      r_ptr        <= '0;
      r_valid_a    <= 1'b0;
      r_valid_b    <= 1'b0;
      r_fetch_pend <= 1'b0;
      r_wcnt       <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_store_prev <= i_store_req;
      r_fetch_prev <= i_fetch_req;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;

      // Any request edge while busy is dropped. A fetch arriving together
      // with a store in IDLE is not dropped; it is queued as fetch_pend.
      if (r_state != S_IDLE && (w_store_pulse || w_fetch_pulse))
        r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_store_pulse) begin
            r_ptr        <= w_ptr_next;
            r_mem_addr   <= w_ptr_next;
            r_mem_din    <= i_store_data;
            r_mem_write  <= 1'b1;
            r_fetch_pend <= w_fetch_pulse;
            if (i_store_slot) begin
              r_addr_b  <= w_ptr_next;
              r_valid_b <= 1'b1;
            end else begin
              r_addr_a  <= w_ptr_next;
              r_valid_a <= 1'b1;
            end
            r_state <= S_WRITE;
          end else if (w_fetch_pulse) begin
            if (r_valid_a && r_valid_b) begin
              r_mem_read <= 1'b1;
              r_mem_addr <= r_addr_a;
              r_state    <= S_RD_A;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          if (r_fetch_pend) begin
            r_fetch_pend <= 1'b0;
            // Valid bits already include the store that just completed.
            if (r_valid_a && r_valid_b) begin
              r_mem_read <= 1'b1;
              r_mem_addr <= r_addr_a;
              r_state    <= S_RD_A;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RD_A: begin
          r_wcnt  <= 2'(RD_LAT - 1);
          r_state <= S_WAIT_A;
        end
        S_WAIT_A: begin
          if (r_wcnt == 2'd0) begin
            r_op_a     <= i_mem_dout;
            r_mem_read <= 1'b1;
            r_mem_addr <= r_addr_b;
            r_state    <= S_RD_B;
          end else begin
            r_wcnt <= r_wcnt - 2'd1;
          end
        end
        S_RD_B: begin
          r_wcnt  <= 2'(RD_LAT - 1);
          r_state <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (r_wcnt == 2'd0) begin
            r_op_b  <= i_mem_dout;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt - 2'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_din   = r_mem_din;
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_addr_a    = r_addr_a;
  assign o_addr_b    = r_addr_b;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
module tb_dmem_seq_ctrl;
  localparam int AW = 8;
  localparam int L  = 1;
  localparam int N  = 4096;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_store_req = 0, i_store_slot = 0, i_fetch_req = 0;
  logic [31:0] i_store_data = 0, i_mem_dout;
  logic o_mem_read, o_mem_write, o_busy, o_done, o_err;
  logic [AW-1:0] o_mem_addr, o_addr_a, o_addr_b;
  logic [31:0] o_mem_din, o_op_a, o_op_b;

  int n_chk = 0, n_err = 0, cyc = 0;

  dmem_seq_ctrl #(.ADDR_W(AW), .RD_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_store_req(i_store_req), .i_store_slot(i_store_slot),
    .i_store_data(i_store_data), .i_fetch_req(i_fetch_req),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din), .i_mem_dout(i_mem_dout),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_addr_a(o_addr_a), .o_addr_b(o_addr_b),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- DMem model (RD_LAT-deep read pipe) ----------------
  logic [31:0] dmem [0:255];
  logic [31:0] rd_pipe [0:L-1];
  int wr_log[$], rd_log[$];
  assign i_mem_dout = rd_pipe[L-1];
  always @(posedge clk) begin
    if (o_mem_write) begin
      dmem[o_mem_addr] <= o_mem_din;
      wr_log.push_back(int'(o_mem_addr));
    end
    if (o_mem_read) rd_log.push_back(int'(o_mem_addr));
    rd_pipe[0] <= dmem[o_mem_addr];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // ---------------- behavioural model: per-interval expectation timeline ----
  bit e_wr[N], e_rd[N], e_busy[N], e_done[N], e_err[N];
  bit e_addr_v[N], e_din_v[N], e_opa_v[N], e_opb_v[N], e_aa_v[N], e_ab_v[N];
  logic [AW-1:0] e_addr[N], e_aa[N], e_ab[N];
  logic [31:0] e_din[N], e_opa[N], e_opb[N];
  logic [31:0] m_mem [0:255];
  logic [AW-1:0] m_ptr = 0, m_aa = 0, m_ab = 0;
  bit m_va = 0, m_vb = 0, m_sprev = 0, m_fprev = 0;
  int m_free = 0;

  task automatic clr(input int i);
    e_wr[i]=0; e_rd[i]=0; e_busy[i]=0; e_done[i]=0; e_err[i]=0;
    e_addr_v[i]=0; e_din_v[i]=0; e_opa_v[i]=0; e_opb_v[i]=0; e_aa_v[i]=0; e_ab_v[i]=0;
  endtask

  // A fetch decided at the edge opening interval s: read A in s, read B after
  // L wait intervals, done in the last busy interval.
  task automatic do_fetch(input int s);
    if (m_va && m_vb) begin
      for (int i = 0; i <= 2*L+2; i++) e_busy[s+i] = 1;
      e_rd[s] = 1; e_addr_v[s] = 1; e_addr[s] = m_aa;
      e_rd[s+L+1] = 1; e_addr_v[s+L+1] = 1; e_addr[s+L+1] = m_ab;
      e_opa_v[s+L+1] = 1; e_opa[s+L+1] = m_mem[m_aa];
      e_opb_v[s+2*L+2] = 1; e_opb[s+2*L+2] = m_mem[m_ab];
      e_done[s+2*L+2] = 1;
      m_free = s + 2*L + 4;
    end else begin
      e_err[s] = 1;
      m_free = s + 1;
    end
  endtask

  always @(posedge clk) begin
    bit sp, fp;
    int t;
    cyc = cyc + 1;
    t = cyc;
    if (!rst_n) begin
      m_ptr = 0; m_aa = 0; m_ab = 0; m_va = 0; m_vb = 0;
      m_sprev = 0; m_fprev = 0; m_free = 0;
      for (int i = 0; i < 32; i++) if (t + i < N) clr(t + i);
    end else begin
      sp = i_store_req & ~m_sprev;
      fp = i_fetch_req & ~m_fprev;
      m_sprev = i_store_req;
      m_fprev = i_fetch_req;
      if (t < m_free) begin
        if (sp || fp) e_err[t] = 1;
      end else if (sp) begin
        m_ptr = (m_ptr == 8'hFF) ? 8'd1 : m_ptr + 8'd1;
        m_mem[m_ptr] = i_store_data;
        e_wr[t] = 1; e_busy[t] = 1;
        e_addr_v[t] = 1; e_addr[t] = m_ptr;
        e_din_v[t] = 1; e_din[t] = i_store_data;
        if (i_store_slot) begin m_ab = m_ptr; m_vb = 1; e_ab_v[t] = 1; e_ab[t] = m_ptr; end
        else begin m_aa = m_ptr; m_va = 1; e_aa_v[t] = 1; e_aa[t] = m_ptr; end
        m_free = t + 2;
        if (fp) do_fetch(t + 1);
      end else if (fp) begin
        do_fetch(t);
      end
    end
  end

  // ---------------- compare process ----------------
  logic [AW-1:0] h_addr = 0, h_aa = 0, h_ab = 0;
  logic [31:0] h_din = 0, h_opa = 0, h_opb = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      h_addr = 0; h_aa = 0; h_ab = 0; h_din = 0; h_opa = 0; h_opb = 0;
      chk("rst_mem_read", 32'(o_mem_read), 0);
      chk("rst_mem_write", 32'(o_mem_write), 0);
      chk("rst_mem_addr", 32'(o_mem_addr), 0);
      chk("rst_mem_din", o_mem_din, 0);
      chk("rst_op_a", o_op_a, 0);
      chk("rst_op_b", o_op_b, 0);
      chk("rst_addr_a", 32'(o_addr_a), 0);
      chk("rst_addr_b", 32'(o_addr_b), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_err", 32'(o_err), 0);
    end else if (cyc > 0 && cyc < N) begin
      if (e_addr_v[cyc]) h_addr = e_addr[cyc];
      if (e_din_v[cyc])  h_din  = e_din[cyc];
      if (e_opa_v[cyc])  h_opa  = e_opa[cyc];
      if (e_opb_v[cyc])  h_opb  = e_opb[cyc];
      if (e_aa_v[cyc])   h_aa   = e_aa[cyc];
      if (e_ab_v[cyc])   h_ab   = e_ab[cyc];
      chk("mem_write", 32'(o_mem_write), 32'(e_wr[cyc]));
      chk("mem_read", 32'(o_mem_read), 32'(e_rd[cyc]));
      chk("mem_addr", 32'(o_mem_addr), 32'(h_addr));
      chk("mem_din", o_mem_din, h_din);
      chk("busy", 32'(o_busy), 32'(e_busy[cyc]));
      chk("done", 32'(o_done), 32'(e_done[cyc]));
      chk("err", 32'(o_err), 32'(e_err[cyc]));
      chk("op_a", o_op_a, h_opa);
      chk("op_b", o_op_b, h_opb);
      chk("addr_a", 32'(o_addr_a), 32'(h_aa));
      chk("addr_b", 32'(o_addr_b), 32'(h_ab));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  // One-interval request; returns inside the first interval after the sampling edge.
  task automatic pulse(input logic st, input logic fe, input logic slot, input logic [31:0] d);
    tick();
    i_store_req = st; i_fetch_req = fe; i_store_slot = slot; i_store_data = d;
    tick();
    i_store_req = 0; i_fetch_req = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (o_busy && k < 40) begin tick(); k++; end
    chk("idle_timeout", 32'(k < 40), 1);
  endtask

  task automatic do_reset();
    tick(); rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
  endtask

  int kd;
  initial begin
    repeat (3) tick();
    rst_n = 1;

    // fetch straight after reset: one err pulse, no memory activity
    pulse(0, 1, 0, 0);
    chk("lit_nofetch_err", 32'(o_err), 1);
    chk("lit_nofetch_rd", 32'(o_mem_read), 0);
    chk("lit_nofetch_busy", 32'(o_busy), 0);
    tick();
    chk("lit_nofetch_err_clr", 32'(o_err), 0);

    // first store: one write cycle at address 1
    tick();
    i_store_req = 1; i_store_slot = 0; i_store_data = 32'hA5;
    @(posedge clk); #1;
    chk("lit_st1_wr", 32'(o_mem_write), 1);
    chk("lit_st1_addr", 32'(o_mem_addr), 1);
    chk("lit_st1_din", o_mem_din, 32'hA5);
    chk("lit_st1_busy", 32'(o_busy), 1);
    @(posedge clk); #1;
    chk("lit_st1_busy_end", 32'(o_busy), 0);
    chk("lit_st1_addr_a", 32'(o_addr_a), 1);
    i_store_req = 0;

    // store A=0x12 @1, B=0x34 @2, fetch: done 5 intervals after the pulse
    do_reset();
    pulse(1, 0, 0, 32'h12); wait_idle();
    pulse(1, 0, 1, 32'h34); wait_idle();
    rd_log.delete();
    tick(); i_fetch_req = 1;
    @(posedge clk);
    kd = 0;
    for (int i = 1; i <= 12; i++) begin
      #1;
      if (o_done && kd == 0) kd = i;
      if (i == 1) i_fetch_req = 0;
      @(posedge clk);
    end
    #1;
    chk("lit_fetch_latency", 32'(kd), 5);
    chk("lit_op_a", o_op_a, 32'h12);
    chk("lit_op_b", o_op_b, 32'h34);
    chk("lit_rd_cnt", 32'(rd_log.size()), 2);
    if (rd_log.size() == 2) begin
      chk("lit_rd0", 32'(rd_log[0]), 1);
      chk("lit_rd1", 32'(rd_log[1]), 2);
    end

    // simultaneous store(B=0x77) + fetch: write @3, then read 1 and 3
    rd_log.delete(); wr_log.delete();
    pulse(1, 1, 1, 32'h77); wait_idle();
    chk("lit_sim_wr_cnt", 32'(wr_log.size()), 1);
    if (wr_log.size() == 1) chk("lit_sim_wr_addr", 32'(wr_log[0]), 3);
    chk("lit_sim_rd_cnt", 32'(rd_log.size()), 2);
    if (rd_log.size() == 2) begin
      chk("lit_sim_rd0", 32'(rd_log[0]), 1);
      chk("lit_sim_rd1", 32'(rd_log[1]), 3);
    end
    chk("lit_sim_op_b", o_op_b, 32'h77);
    chk("lit_sim_op_a", o_op_a, 32'h12);

    // store arriving mid-fetch is dropped and cannot disturb addr_b
    pulse(0, 1, 0, 0);
    pulse(1, 0, 1, 32'h99);
    wait_idle();
    chk("lit_drop_addr_b", 32'(o_addr_b), 3);
    chk("lit_drop_op_b", o_op_b, 32'h77);
    pulse(0, 1, 0, 0); wait_idle();

    // level held 10 intervals produces a single write
    wr_log.delete();
    tick(); i_store_req = 1; i_store_slot = 0; i_store_data = 32'h55;
    repeat (10) tick();
    i_store_req = 0;
    wait_idle();
    chk("lit_held_one_write", 32'(wr_log.size()), 1);

    // walk the pointer to 254, then three stores land at 255, 1, 2
    for (int g = 0; g < 300 && m_ptr != 8'd254; g++) begin
      pulse(1, 0, g[0], 32'(g)); wait_idle();
    end
    wr_log.delete();
    pulse(1, 0, 0, 32'hAAAA_0001); wait_idle();
    pulse(1, 0, 1, 32'hBBBB_0002); wait_idle();
    pulse(1, 0, 0, 32'hCCCC_0003); wait_idle();
    chk("lit_wrap_cnt", 32'(wr_log.size()), 3);
    if (wr_log.size() == 3) begin
      chk("lit_wrap0", 32'(wr_log[0]), 255);
      chk("lit_wrap1", 32'(wr_log[1]), 1);
      chk("lit_wrap2", 32'(wr_log[2]), 2);
    end
    pulse(0, 1, 0, 0); wait_idle();
    chk("lit_wrap_op_a", o_op_a, 32'hCCCC_0003);
    chk("lit_wrap_op_b", o_op_b, 32'hBBBB_0002);

    // reset asserted during WAIT_A
    tick(); i_fetch_req = 1;
    @(posedge clk);          // RD_A
    #1 i_fetch_req = 0;
    @(posedge clk);          // WAIT_A
    #2 rst_n = 0;
    #1;
    chk("lit_rst_rd", 32'(o_mem_read), 0);
    chk("lit_rst_busy", 32'(o_busy), 0);
    chk("lit_rst_done", 32'(o_done), 0);
    chk("lit_rst_op_a", o_op_a, 0);
    tick(); tick();
    rst_n = 1;
    pulse(0, 1, 0, 0);
    chk("lit_post_rst_err", 32'(o_err), 1);
    chk("lit_post_rst_busy", 32'(o_busy), 0);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_seq_ctrl.md
Name: dmem_seq_ctrl

Overview:
Sequencer and scheduler for the shared 32-bit data memory (DMem) used by the integer and float operand paths.
- Accepts button-level store and fetch requests and edge-detects them internally.
- Allocates auto-incrementing write addresses and records the latest address per operand slot (A/B).
- On fetch, reads operand A then operand B back-to-back with correct read latency and presents both with a done strobe to the branch/float compare logic.
- Replaces the ad-hoc alternating read toggling in the top-level controller.

Parameters:
ADDR_W, 8, memory address width; pointer wraps within this width.
RD_LAT, 1, DMem read latency in cycles from mem_read/mem_addr to valid mem_dout (1..3).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
store_req  in  1  level request (button); rising edge = one store
store_slot  in  1  0 = operand A, 1 = operand B
store_data  in  32  word to store, sampled on the store_req rising edge
fetch_req  in  1  level request (button); rising edge = one fetch of A then B
mem_read  out  1  DMem read enable
mem_write  out  1  DMem write enable
mem_addr  out  ADDR_W  DMem address
mem_din  out  32  DMem write data
mem_dout  in  32  DMem read data
op_a  out  32  last fetched operand A
op_b  out  32  last fetched operand B
addr_a  out  ADDR_W  address of latest A store
addr_b  out  ADDR_W  address of latest B store
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when op_a/op_b are updated
err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async, rst_n=0): all outputs and internal registers are 0: ptr=0, valid_a=0, valid_b=0, fetch_pend=0, edge-history regs=0, state=IDLE. This applies mid-operation too; an in-flight write or read is abandoned and mem_read/mem_write drop immediately.
- Edge detect: a pulse is `req & ~req_prev`; req_prev is registered every cycle. A level held high yields exactly one pulse.
- All mem_* outputs are registered and driven only in the states listed below; otherwise mem_read=0 and mem_write=0, while mem_addr and mem_din hold.
- States: IDLE, WRITE, RD_A, WAIT_A, RD_B, WAIT_B, DONE.
- IDLE + store pulse:
  - ptr_next = ptr+1, except ptr = 2^ADDR_W-1 wraps to 1; address 0 is never written.
  - ptr, mem_addr, mem_din and the slot address register (addr_a or addr_b) are loaded; valid bit for that slot is set.
  - Next state is WRITE.
- WRITE: exactly one cycle with mem_write=1. Next state is RD_A if fetch_pend is set (fetch_pend cleared), else IDLE.
- IDLE + fetch pulse:
  - If valid_a & valid_b: mem_addr=addr_a, mem_read=1, go to RD_A.
  - Otherwise: err=1 for one cycle, stay in IDLE, no memory activity.
- Simultaneous store and fetch pulse in IDLE: the store is serviced first and fetch_pend=1. The fetch then runs straight after WRITE and uses the freshly updated addresses. If valid_a & valid_b is still false after the write, err pulses and the FSM returns to IDLE.
- RD_A: one cycle, mem_read=1, mem_addr=addr_a.
- WAIT_A: RD_LAT cycles, counted by an internal counter, mem_read=0. On the last cycle, op_a <= mem_dout, mem_addr=addr_b, mem_read=1, next state RD_B.
- RD_B and WAIT_B: same as RD_A/WAIT_A for B, capturing op_b. Next state is DONE.
- DONE: done=1 for one cycle, then IDLE.
- Fetch latency: the pulse is sampled at edge 0. With RD_LAT=1, done is high in cycle 5 (states RD_A, WAIT_A, RD_B, WAIT_B, DONE). In general, done appears 2·RD_LAT+3 cycles after the pulse.
- Any pulse (store or fetch) arriving while busy=1 is dropped and err=1 for one cycle. Exception: a fetch pulse in the same cycle as the IDLE→WRITE transition is handled as the simultaneous case above.
- Fetch addresses are the addr_a/addr_b values at RD_A/RD_B entry. A dropped store cannot alter them during a fetch.
- op_a/op_b change only on capture; they hold between fetches and across err.
- addr_a and addr_b are independent: repeated stores to one slot overwrite only that slot's address.

Test Plan:
- Reset, then store_req rising edge with slot=0, data=0x0000_00A5 → one cycle of mem_write=1, addr=1, din=0xA5; addr_a=1; busy high for exactly 1 cycle.
- Store A=0x12 (addr 1), B=0x34 (addr 2), then fetch with a model DMem at RD_LAT=1 → mem_read seen at addr 1 then addr 2; done in cycle 5 with op_a=0x12, op_b=0x34; err never asserted.
- Fetch immediately after reset → err pulse of 1 cycle, mem_read stays 0, busy stays 0.
- store_req and fetch_req rise in the same cycle (A and B already valid, slot=1, data=0x77) → write to addr 3 first, then fetch reads addr_a=1 and addr_b=3; op_b=0x77.
- Force ptr to 254 with ADDR_W=8, then issue 3 stores → addresses 255, 1, 2 (0 skipped); store_req held high 10 cycles produces only one write.
- Assert rst_n=0 during WAIT_A → mem_read, busy and done go 0 asynchronously; op_a=0, valid flags cleared, so the next fetch gives err.
